// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding results in HI/LO; start/busy handshake.
// Optional madd/msub (md_op 7/8) is enabled by defining MDU_MADD_EN.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [CW-1:0]     cnt;
    logic [3:0]        op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;

    logic              is_long;
    logic              is_mul;
    logic              res_wr;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;
    logic [63:0]       prod_s;
    logic [63:0]       prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb;

    assign busy = (state == ST_RUN);

    always_comb begin
        is_long = 1'b0;
        is_mul  = 1'b0;
        case (md_op)
            OP_MULT, OP_MULTU: begin is_long = 1'b1; is_mul = 1'b1; end
            OP_DIV, OP_DIVU:   is_long = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB:  begin is_long = 1'b1; is_mul = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Results are formed from the latched operands and only consumed on the completion edge.
    always_comb begin
        sa     = a_q;
        sb     = b_q;
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        res_wr = 1'b0;
        res_hi = hi;
        res_lo = lo;
        case (op_q)
            OP_MULT: begin
                res_wr = 1'b1;
                {res_hi, res_lo} = prod_s;
            end
            OP_MULTU: begin
                res_wr = 1'b1;
                {res_hi, res_lo} = prod_u;
            end
            OP_DIV: begin
                if (b_q != '0) begin
                    res_wr = 1'b1;
                    if (a_q == 32'h8000_0000 && b_q == '1) begin
                        res_lo = 32'h8000_0000;
                        res_hi = '0;
                    end else begin
                        res_lo = sa / sb;
                        res_hi = sa % sb;
                    end
                end
            end
            OP_DIVU: begin
                if (b_q != '0) begin
                    res_wr = 1'b1;
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                res_wr = 1'b1;
                {res_hi, res_lo} = {hi, lo} + prod_s;
            end
            OP_MSUB: begin
                res_wr = 1'b1;
                {res_hi, res_lo} = {hi, lo} - prod_s;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                if (is_long) begin
                    op_q  <= md_op;
                    a_q   <= a;
                    b_q   <= b;
                    cnt   <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    state <= ST_RUN;
                end else if (md_op == OP_MTHI) begin
                    hi <= a;
                end else if (md_op == OP_MTLO) begin
                    lo <= a;
                end
            end
        end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state <= ST_IDLE;
                if (res_wr) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end
    end

endmodule
